// File: rtl/core_seq.sv
// Multicycle sequencer for the RISC-V core: owns the PC and the FETCH/DECODE/EXEC/MEM/WRITE_BACK state machine.
// Optional `CORE_SEQ_PERF_CNT_EN adds 64-bit cycle and retired-instruction counters.
module core_seq #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     PC_STEP   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            imem_ready_i,
  input  logic            dmem_ready_i,
  input  logic            is_calc_i,
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] link_o,
  output logic [2:0]      state_o,
  output logic            imem_req_o,
  output logic            ir_we_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic            rf_we_o,
  output logic            retire_o
`ifdef CORE_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt_o,
  output logic [63:0]     instret_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] target_q;
  logic            taken_q;
  logic            calc_q, load_q, store_q, branch_q, jal_q, jalr_q;

  assign pc_o    = pc_q;
  assign link_o  = pc_q + STEP;
  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    retire_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (load_q || store_q) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = store_q;
        if (dmem_ready_i) state_d = S_WB;
      end
      S_WB: begin
        rf_we_o  = calc_q | load_q | jal_q | jalr_q;
        retire_o = 1'b1;
        state_d  = S_FETCH;
        if (jalr_q)                   pc_d = {target_q[XLEN-1:1], 1'b0};
        else if (jal_q)               pc_d = target_q;
        else if (branch_q && taken_q) pc_d = target_q;
        else                          pc_d = pc_q + STEP;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset cycle abandons the instruction: no strobe may escape it.
    if (rst_i) begin
      imem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      rf_we_o    = 1'b0;
      retire_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_VEC;
      target_q <= '0;
      taken_q  <= 1'b0;
      calc_q   <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      branch_q <= 1'b0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_DECODE) begin
        calc_q   <= is_calc_i;
        load_q   <= is_load_i;
        store_q  <= is_store_i;
        branch_q <= is_branch_i;
        jal_q    <= is_jal_i;
        jalr_q   <= is_jalr_i;
      end
      if (state_q == S_EXEC) begin
        taken_q  <= branch_taken_i;
        target_q <= target_i;
      end
    end
  end

`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (retire_o) instret_cnt_q <= instret_cnt_q + 64'd1;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: directed instruction vectors push expected retire records,
// a negedge monitor pops and compares at every retire_o.
module tb_core_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_ready_i, dmem_ready_i;
  logic        is_calc_i, is_load_i, is_store_i, is_branch_i, is_jal_i, is_jalr_i;
  logic        branch_taken_i;
  logic [31:0] target_i;
  logic [31:0] pc_o, link_o;
  logic [2:0]  state_o;
  logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, retire_o;
`ifdef CORE_SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt_o, instret_cnt_o;
`endif

  core_seq #(.XLEN(32), .RESET_VEC(32'h100), .PC_STEP(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
    .is_calc_i(is_calc_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
    .branch_taken_i(branch_taken_i), .target_i(target_i),
    .pc_o(pc_o), .link_o(link_o), .state_o(state_o),
    .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o), .retire_o(retire_o)
`ifdef CORE_SEQ_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .instret_cnt_o(instret_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc, link, nxt;
    int unsigned rf, lat, memc, we;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0, n_fail = 0;
  int unsigned imem_delay = 0, dmem_delay = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Ready responder: ready held high outside its own state so stray readies are exercised.
  int unsigned fcnt = 0, mcnt = 0;
  always @(posedge clk_i) begin
    #3;
    if (!rst_i && state_o == 3'd0) begin
      imem_ready_i = (fcnt >= imem_delay);
      fcnt++;
    end else begin
      imem_ready_i = 1'b1;
      fcnt = 0;
    end
    if (!rst_i && state_o == 3'd3) begin
      dmem_ready_i = (mcnt >= dmem_delay);
      mcnt++;
    end else begin
      dmem_ready_i = 1'b1;
      mcnt = 0;
    end
  end

  // Monitor: per-instruction activity counters, compared against the scoreboard at retire.
  int unsigned icyc = 0, mcyc = 0, wecnt = 0, rfcnt = 0;
  logic        chk_next = 1'b0;
  logic [31:0] next_pc = '0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      icyc = 0; mcyc = 0; wecnt = 0; rfcnt = 0; chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        chk("next_pc", pc_o, next_pc);
        chk_next = 1'b0;
      end
      icyc++;
      if (dmem_req_o) mcyc++;
      if (dmem_we_o) wecnt++;
      if (rf_we_o) rfcnt++;
      if (retire_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_pc", pc_o, e.pc);
          chk("wb_link", link_o, e.link);
          chk("rf_we_count", rfcnt, e.rf);
          chk("latency", icyc, e.lat);
          chk("mem_cycles", mcyc, e.memc);
          chk("dmem_we_count", wecnt, e.we);
          next_pc  = e.nxt;
          chk_next = 1'b1;
        end
        icyc = 0; mcyc = 0; wecnt = 0; rfcnt = 0;
      end
    end
  end

  task automatic set_flags(input logic [5:0] f, input logic tk, input logic [31:0] tgt);
    {is_calc_i, is_load_i, is_store_i, is_branch_i, is_jal_i, is_jalr_i} = f;
    branch_taken_i = tk;
    target_i       = tgt;
  endtask

  // Called at posedge+2 with the DUT in FETCH; returns at posedge+2 of the next FETCH.
  task automatic issue(input logic [5:0] f, input logic tk, input logic [31:0] tgt,
                       input int unsigned idl, input int unsigned dly,
                       input logic [31:0] epc, input logic [31:0] elink, input logic [31:0] enxt,
                       input int unsigned erf, input int unsigned elat,
                       input int unsigned emem, input int unsigned ewe);
    exp_t e;
    logic seen_wb, done;
    e.pc = epc; e.link = elink; e.nxt = enxt;
    e.rf = erf; e.lat = elat; e.memc = emem; e.we = ewe;
    sb.push_back(e);
    set_flags(f, tk, tgt);
    imem_delay = idl;
    dmem_delay = dly;
    seen_wb = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk_i);
      #2;
      if (state_o == 3'd4) seen_wb = 1'b1;
      else if (seen_wb && state_o == 3'd0) done = 1'b1;
    end
    if (!done) chk("instr_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    imem_ready_i = 1'b1;
    dmem_ready_i = 1'b1;
    set_flags(6'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_link", link_o, 32'h104);
    chk("rst_state", state_o, 3'd0);
    chk("rst_strobes", {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, retire_o}, 6'b0);
`ifdef CORE_SEQ_PERF_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt_o, 64'd0);
`endif
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    //     flags {calc,load,store,branch,jal,jalr}  tk  target  idl dly  pc  link  next  rf lat mem we
    issue(6'b100000, 1'b0, 32'h0,        0, 0, 32'h100,      32'h104, 32'h104,      1, 4, 0, 0);
    issue(6'b010000, 1'b0, 32'h0,        0, 3, 32'h104,      32'h108, 32'h108,      1, 8, 4, 0);
    issue(6'b001000, 1'b0, 32'h0,        0, 0, 32'h108,      32'h10C, 32'h10C,      0, 5, 1, 1);
    issue(6'b000100, 1'b1, 32'h200,      0, 0, 32'h10C,      32'h110, 32'h200,      0, 4, 0, 0);
    issue(6'b000100, 1'b0, 32'h40,       0, 0, 32'h200,      32'h204, 32'h204,      0, 4, 0, 0);
    issue(6'b000001, 1'b0, 32'h301,      0, 0, 32'h204,      32'h208, 32'h300,      1, 4, 0, 0);
    issue(6'b000010, 1'b0, 32'hFFFFFFFC, 0, 0, 32'h300,      32'h304, 32'hFFFFFFFC, 1, 4, 0, 0);
    issue(6'b100000, 1'b0, 32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, 4, 0, 0);
    issue(6'b000000, 1'b1, 32'h77,       2, 0, 32'h0,        32'h4,   32'h4,        0, 6, 0, 0);
    issue(6'b000111, 1'b1, 32'h81,       0, 0, 32'h4,        32'h8,   32'h80,       1, 4, 0, 0);
    issue(6'b100000, 1'b1, 32'h999,      0, 0, 32'h80,       32'h84,  32'h84,       1, 4, 0, 0);
    issue(6'b000110, 1'b0, 32'h500,      0, 0, 32'h84,       32'h88,  32'h500,      1, 4, 0, 0);

    // Load abandoned by reset while waiting in MEM.
    set_flags(6'b010000, 1'b0, 32'h0);
    dmem_delay = 50;
    for (int i = 0; i < 20 && state_o != 3'd3; i++) begin
      @(posedge clk_i);
      #2;
    end
    chk("reached_mem", state_o, 3'd3);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_in_mem_strobes", {dmem_req_o, dmem_we_o, rf_we_o, retire_o}, 4'b0);
    @(posedge clk_i);
    #2;
    chk("rst_in_mem_state", state_o, 3'd0);
    chk("rst_in_mem_pc", pc_o, 32'h100);
    rst_i = 1'b0;
    issue(6'b100000, 1'b0, 32'h0, 0, 0, 32'h100, 32'h104, 32'h104, 1, 4, 0, 0);

`ifdef CORE_SEQ_PERF_CNT_EN
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] p;
      p = 32'h100 + 32'(4 * k);
      issue(6'b100000, 1'b0, 32'h0, 0, 0, p, p + 32'h4, p + 32'h4, 1, 4, 0, 0);
    end
    chk("instret_cnt", instret_cnt_o, 64'd10);
    chk("cycle_cnt", cycle_cnt_o, 64'd40);
`endif

    @(negedge clk_i);
    #1;
    chk("scoreboard_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
